multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the MIPS32 core.
- Issues instruction-fetch and data-memory requests and consumes the decoder's op_flags_t.
- Drives every datapath enable and mux select: PC, IR, register file, ALU, memory.
- Retires one instruction at a time; halts on syscall or an illegal/non-one-hot decode.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  10  op_flags_t from decoder, field order {alu_r, ori, lui, lw, sw, beq, j, jal, jr, syscall}; sampled only in DECODE.
- funct  input  6  instr[5:0]; 0x23 selects subtract for alu_r.
- alu_zero  input  1  ALU result==0, sampled in EXEC for beq.
- imem_req  output  1  fetch request.
- imem_ready  input  1  fetch data valid this cycle.
- dmem_req  output  1  data request.
- dmem_we  output  1  1=store, 0=load; valid with dmem_req.
- dmem_ready  input  1  data access completes this cycle.
- ir_we  output  1  latch instruction register.
- pc_we  output  1  update PC.
- pc_src  output  2  0=pc+4, 1=branch target, 2=jump target, 3=rs.
- alu_op  output  2  0=add, 1=sub, 2=or, 3=lui (imm<<16).
- alu_src_imm  output  1  0=rt, 1=extended immediate.
- reg_we  output  1  register-file write.
- reg_dst  output  2  0=rt, 1=rd, 2=$31.
- wb_sel  output  2  0=ALU result, 1=load data, 2=pc+4.
- halted  output  1  sticky halt.
- illegal  output  1  sticky; set when halt was caused by a bad decode.
- retired_count  output  CNT_W  instructions completed.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Registered state; outputs are Moore decodes of state plus a latched op copy.
- Latch op and funct in DECODE.
- Reset (async assert, sync-to-clk release):
  - State becomes FETCH.
  - halted, illegal and retired_count become 0.
  - All strobes (imem_req, dmem_req, ir_we, pc_we, reg_we) become 0; all selects become 0.
  - Reset mid-operation abandons the instruction; no partial writes occur after reset.
- FETCH:
  - imem_req=1 is held continuously until imem_ready.
  - In the imem_ready cycle, ir_we=1 and next state is DECODE.
  - Otherwise stay in FETCH; ir_we=0.
- DECODE (1 cycle):
  - If op is not one-hot (zero or multiple bits set): illegal<=1, go to HALT.
  - syscall: go to HALT, retired_count+1.
  - j: pc_we=1, pc_src=2, retired_count+1, go to FETCH.
  - jr: pc_we=1, pc_src=3, retired_count+1, go to FETCH.
  - jal: go to WB.
  - Any other op: go to EXEC.
- EXEC (1 cycle):
  - alu_r: alu_src_imm=0, alu_op = (funct==0x23) ? 1 : 0.
  - ori: alu_src_imm=1, alu_op=2.
  - lui: alu_src_imm=1, alu_op=3.
  - lw/sw: alu_src_imm=1, alu_op=0.
  - beq: alu_src_imm=0, alu_op=1; pc_we=1; pc_src = alu_zero ? 1 : 0; retired_count+1; go to FETCH.
  - alu_r/ori/lui go to WB; lw/sw go to MEM.
- MEM:
  - dmem_req=1 and dmem_we=sw are held until dmem_ready.
  - On dmem_ready: sw does pc_we=1, pc_src=0, retired_count+1, go to FETCH; lw goes to WB.
- WB (1 cycle): reg_we=1, pc_we=1, retired_count+1, go to FETCH.
  - alu_r: reg_dst=1, wb_sel=0, pc_src=0.
  - ori/lui: reg_dst=0, wb_sel=0, pc_src=0.
  - lw: reg_dst=0, wb_sel=1, pc_src=0.
  - jal: reg_dst=2, wb_sel=2, pc_src=2.
- HALT: absorbing until reset. halted=1 and all strobes are 0.
- Zero-wait latencies (cycles from entering FETCH to next FETCH):
  - addu/ori/lui: 4. lw: 5. sw: 4. beq: 3. j/jr: 2. jal: 3.
- Each ready stall adds one cycle per stalled cycle.
- Strobe rules:
  - ir_we, pc_we and reg_we each pulse for exactly one cycle per instruction.
  - pc_we and reg_we never assert in the same cycle as imem_req.
  - imem_req and dmem_req are never both high.
- A ready input arriving while the matching req is low is ignored.
- retired_count wraps from all-ones to 0.

Test Plan:
- addu, zero waits: op=alu_r, funct=0x21, imem_ready tied 1 -> ir_we in cycle 0; EXEC alu_op=0; WB reg_we=1, reg_dst=1, pc_we=1; next FETCH at cycle 4; retired_count=1.
- lw with 3-cycle dmem stall: dmem_req/dmem_we=0 held 3 cycles then dmem_ready -> WB wb_sel=1, reg_dst=0; total 8 cycles; sw variant -> dmem_we=1, no reg_we.
- beq: alu_zero=1 -> pc_src=1, pc_we in EXEC. alu_zero=0 -> pc_src=0. Both cases take 3 cycles.
- jal then jr: jal -> WB reg_dst=2, wb_sel=2, pc_src=2. jr -> pc_src=3 in DECODE. retired_count increases by 2.
- syscall -> halted=1, illegal=0, retired_count+1, no further imem_req. op=0 or op with alu_r and lw both set -> halted=1, illegal=1.
- Assert rst_n low during MEM with dmem_req high -> dmem_req drops asynchronously; after release, FETCH with imem_req=1 and count 0. Count preset via 2^CNT_W-1 retirements (CNT_W=4) -> wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS32 core: fetch/decode/exec/mem/wb with
// Moore-style datapath controls, sticky halt on syscall or bad decode.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       op,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    // state  | meaning
    // FETCH  | imem_req held until imem_ready; ir_we in the ready cycle
    // DECODE | latch op/funct, resolve j/jr/syscall/bad decode
    // EXEC   | ALU controls; beq resolves and retires here
    // MEM    | dmem_req held until dmem_ready
    // WB     | register write, PC update, retire
    // HALT   | absorbing until reset
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int B_ALUR = 9;
    localparam int B_ORI  = 8;
    localparam int B_LUI  = 7;
    localparam int B_LW   = 6;
    localparam int B_SW   = 5;
    localparam int B_BEQ  = 4;
    localparam int B_J    = 3;
    localparam int B_JAL  = 2;
    localparam int B_JR   = 1;
    localparam int B_SYS  = 0;

    state_t           state_q, state_d;
    logic [9:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             op_onehot;

    assign op_onehot     = (op != 10'd0) && ((op & (op - 10'd1)) == 10'd0);
    assign illegal       = illegal_q;
    assign retired_count = cnt_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        funct_d     = funct_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_op      = 2'd0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wb_sel      = 2'd0;
        halted      = 1'b0;

        // Controls are forced quiet while reset is held so nothing leaks mid-assert.
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_d    = op;
                    funct_d = funct;
                    if (!op_onehot) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end else if (op[B_SYS]) begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end else if (op[B_J] || op[B_JR]) begin
                        pc_we   = 1'b1;
                        pc_src  = op[B_JR] ? 2'd3 : 2'd2;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (op[B_JAL]) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_src_imm = !(op_q[B_ALUR] || op_q[B_BEQ]);
                    if (op_q[B_ALUR])     alu_op = (funct_q == 6'h23) ? 2'd1 : 2'd0;
                    else if (op_q[B_ORI]) alu_op = 2'd2;
                    else if (op_q[B_LUI]) alu_op = 2'd3;
                    else if (op_q[B_BEQ]) alu_op = 2'd1;
                    else                  alu_op = 2'd0;
                    if (op_q[B_BEQ]) begin
                        pc_we   = 1'b1;
                        pc_src  = alu_zero ? 2'd1 : 2'd0;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else if (op_q[B_LW] || op_q[B_SW]) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = op_q[B_SW];
                    if (dmem_ready) begin
                        if (op_q[B_SW]) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (op_q[B_ALUR])     reg_dst = 2'd1;
                    else if (op_q[B_JAL]) reg_dst = 2'd2;
                    if (op_q[B_LW])       wb_sel = 2'd1;
                    else if (op_q[B_JAL]) wb_sel = 2'd2;
                    if (op_q[B_JAL])      pc_src = 2'd2;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end

        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= 10'd0;
            funct_q   <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller; expected per-cycle strobes come from
// the instruction phase sequence and latency rules, counts from a retirement tally.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] op;
    logic [5:0] funct;
    logic       alu_zero, imem_ready, dmem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, reg_we, halted, illegal;
    logic [1:0] pc_src, alu_op, reg_dst, wb_sel;
    logic [31:0] retired_count;

    logic       imem_req_4, dmem_req_4, dmem_we_4, ir_we_4, pc_we_4, alu_src_imm_4, reg_we_4, halted_4, illegal_4;
    logic [1:0] pc_src_4, alu_op_4, reg_dst_4, wb_sel_4;
    logic [3:0] retired_count_4;

    int checks = 0;
    int errors = 0;
    int unsigned model_cnt = 0;

    localparam int K_ALUR = 9, K_ORI = 8, K_LUI = 7, K_LW = 6, K_SW = 5;
    localparam int K_BEQ = 4, K_J = 3, K_JAL = 2, K_JR = 1, K_SYS = 0;
    localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal), .retired_count(retired_count)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .alu_zero(alu_zero),
        .imem_req(imem_req_4), .imem_ready(imem_ready), .dmem_req(dmem_req_4), .dmem_we(dmem_we_4),
        .dmem_ready(dmem_ready), .ir_we(ir_we_4), .pc_we(pc_we_4), .pc_src(pc_src_4), .alu_op(alu_op_4),
        .alu_src_imm(alu_src_imm_4), .reg_we(reg_we_4), .reg_dst(reg_dst_4), .wb_sel(wb_sel_4),
        .halted(halted_4), .illegal(illegal_4), .retired_count(retired_count_4)
    );

    task automatic test_reset();
        logic [16:0] got;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        op         = 10'd0;
        funct      = 6'd0;
        alu_zero   = 1'b0;
        #1;
        model_cnt = 0;
        got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
               reg_we, reg_dst, wb_sel, halted, illegal};
        checks++;
        if (got !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0", got);
        end
        checks++;
        if (retired_count !== 32'd0 || retired_count_4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d/%0d exp=0", retired_count, retired_count_4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input int k, input logic [5:0] fn, input logic az,
                             input int istall, input int dstall);
        int ph[$];
        int last;
        logic [5:0] exp_s, got_s;
        logic [1:0] exp_pcsrc, exp_aluop, exp_dst, exp_wb;
        logic exp_imm;
        for (int i = 0; i <= istall; i++) ph.push_back(PF);
        ph.push_back(PD);
        if (k == K_ALUR || k == K_ORI || k == K_LUI) begin
            ph.push_back(PE); ph.push_back(PW);
        end else if (k == K_LW || k == K_SW) begin
            ph.push_back(PE);
            for (int i = 0; i <= dstall; i++) ph.push_back(PM);
            if (k == K_LW) ph.push_back(PW);
        end else if (k == K_BEQ) begin
            ph.push_back(PE);
        end else if (k == K_JAL) begin
            ph.push_back(PW);
        end
        last = ph.size() - 1;
        exp_pcsrc = (k == K_BEQ) ? {1'b0, az} : (k == K_J || k == K_JAL) ? 2'd2 :
                    (k == K_JR) ? 2'd3 : 2'd0;
        exp_aluop = (k == K_ALUR) ? ((fn == 6'h23) ? 2'd1 : 2'd0) : (k == K_ORI) ? 2'd2 :
                    (k == K_LUI) ? 2'd3 : (k == K_BEQ) ? 2'd1 : 2'd0;
        exp_imm   = !(k == K_ALUR || k == K_BEQ);
        exp_dst   = (k == K_ALUR) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;
        exp_wb    = (k == K_LW) ? 2'd1 : (k == K_JAL) ? 2'd2 : 2'd0;

        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            imem_ready = (ph[i] == PF) ? (i == istall) : 1'($urandom);
            if (ph[i] == PM) dmem_ready = (i == last) ? 1'b1 : (ph[i+1] != PM);
            else             dmem_ready = 1'($urandom);
            op       = (ph[i] == PD) ? 10'(1 << k) : 10'($urandom);
            funct    = (ph[i] == PD) ? fn : 6'($urandom);
            alu_zero = (ph[i] == PE) ? az : 1'($urandom);
            #1;
            exp_s = {ph[i] == PF, (ph[i] == PF) && (i == istall), ph[i] == PM,
                     i == last, ph[i] == PW, 1'b0};
            got_s = {imem_req, ir_we, dmem_req, pc_we, reg_we, halted};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL strobes kind=%0d cyc=%0d got=%b exp=%b", k, i, got_s, exp_s);
            end
            checks++;
            if (retired_count !== model_cnt || retired_count_4 !== 4'(model_cnt)) begin
                errors++;
                $display("FAIL count kind=%0d cyc=%0d got=%0d/%0d exp=%0d", k, i,
                         retired_count, retired_count_4, model_cnt);
            end
            if (ph[i] == PM) begin
                checks++;
                if (dmem_we !== (k == K_SW)) begin
                    errors++;
                    $display("FAIL dmem_we kind=%0d cyc=%0d got=%b exp=%b", k, i, dmem_we, k == K_SW);
                end
            end
            if (ph[i] == PE) begin
                checks++;
                if ({alu_op, alu_src_imm} !== {exp_aluop, exp_imm}) begin
                    errors++;
                    $display("FAIL alu_ctl kind=%0d got=%b exp=%b", k, {alu_op, alu_src_imm},
                             {exp_aluop, exp_imm});
                end
            end
            if (ph[i] == PW) begin
                checks++;
                if ({reg_dst, wb_sel} !== {exp_dst, exp_wb}) begin
                    errors++;
                    $display("FAIL wb_ctl kind=%0d got=%b exp=%b", k, {reg_dst, wb_sel}, {exp_dst, exp_wb});
                end
            end
            if (i == last) begin
                checks++;
                if (pc_src !== exp_pcsrc) begin
                    errors++;
                    $display("FAIL pc_src kind=%0d got=%0d exp=%0d", k, pc_src, exp_pcsrc);
                end
            end
        end
        model_cnt++;
    endtask

    task automatic run_halt(input logic [9:0] opv, input logic exp_ill, input int exp_ret);
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'($urandom); op = 10'($urandom);
        #1;
        checks++;
        if ({imem_req, ir_we} !== 2'b11) begin
            errors++;
            $display("FAIL halt_fetch got=%b exp=11", {imem_req, ir_we});
        end
        @(negedge clk);
        op = opv; imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
        #1;
        checks++;
        if ({imem_req, ir_we, dmem_req, pc_we, reg_we, halted} !== 6'd0) begin
            errors++;
            $display("FAIL halt_decode op=%b got=%b exp=0", opv,
                     {imem_req, ir_we, dmem_req, pc_we, reg_we, halted});
        end
        model_cnt += exp_ret;
        repeat (4) begin
            @(negedge clk);
            op = 10'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            alu_zero = 1'($urandom);
            #1;
            checks++;
            if ({imem_req, ir_we, dmem_req, pc_we, reg_we, halted, illegal} !== {6'b000001, exp_ill}) begin
                errors++;
                $display("FAIL halt_state op=%b got=%b exp=%b", opv,
                         {imem_req, ir_we, dmem_req, pc_we, reg_we, halted, illegal}, {6'b000001, exp_ill});
            end
            checks++;
            if (retired_count !== model_cnt || retired_count_4 !== 4'(model_cnt)) begin
                errors++;
                $display("FAIL halt_count got=%0d exp=%0d", retired_count, model_cnt);
            end
        end
    endtask

    task automatic test_alu();
        run_instr(K_ALUR, 6'h21, 1'b0, 0, 0);
        run_instr(K_ALUR, 6'h23, 1'b0, 0, 0);
        run_instr(K_ORI, 6'($urandom), 1'b0, 1, 0);
        run_instr(K_LUI, 6'($urandom), 1'b1, 0, 0);
    endtask

    task automatic test_mem();
        run_instr(K_LW, 6'($urandom), 1'b0, 0, 3);
        run_instr(K_SW, 6'($urandom), 1'b0, 0, 3);
        run_instr(K_LW, 6'($urandom), 1'b0, 0, 0);
        run_instr(K_SW, 6'($urandom), 1'b0, 2, 0);
    endtask

    task automatic test_beq();
        run_instr(K_BEQ, 6'($urandom), 1'b1, 0, 0);
        run_instr(K_BEQ, 6'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_jal_jr();
        run_instr(K_JAL, 6'($urandom), 1'b0, 0, 0);
        run_instr(K_JR, 6'($urandom), 1'b0, 0, 0);
        run_instr(K_J, 6'($urandom), 1'b0, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int k;
            logic [5:0] fn;
            k  = int'($urandom_range(9, 1));
            fn = ($urandom_range(1, 0) == 1) ? 6'h23 : 6'($urandom);
            run_instr(k, fn, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [16:0] got;
        @(negedge clk); imem_ready = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); op = 10'(1 << K_LW); imem_ready = 1'b0;
        @(negedge clk); op = 10'($urandom);
        @(negedge clk); dmem_ready = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we} !== 2'b10) begin
            errors++;
            $display("FAIL midmem_req got=%b exp=10", {dmem_req, dmem_we});
        end
        rst_n = 1'b0;
        #1;
        model_cnt = 0;
        got = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
               reg_we, reg_dst, wb_sel, halted, illegal};
        checks++;
        if (got !== 17'd0 || retired_count !== 32'd0) begin
            errors++;
            $display("FAIL midmem_reset got=%b cnt=%0d exp=0", got, retired_count);
        end
        @(negedge clk);
        rst_n = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
        #1;
        checks++;
        if ({imem_req, ir_we, dmem_req, reg_we} !== 4'b1000) begin
            errors++;
            $display("FAIL midmem_release got=%b exp=1000", {imem_req, ir_we, dmem_req, reg_we});
        end
    endtask

    task automatic test_wrap();
        test_reset();
        repeat (16) run_instr(K_J, 6'($urandom), 1'b0, 0, 0);
        @(negedge clk); imem_ready = 1'b0;
        #1;
        checks++;
        if (retired_count_4 !== 4'd0 || retired_count !== 32'd16) begin
            errors++;
            $display("FAIL wrap got=%0d/%0d exp=0/16", retired_count_4, retired_count);
        end
    endtask

    task automatic test_halt();
        test_reset();
        run_halt(10'b00_0000_0001, 1'b0, 1);
        test_reset();
        run_halt(10'd0, 1'b1, 0);
        test_reset();
        run_halt(10'b10_0100_0000, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_beq();
        test_jal_jr();
        test_random();
        test_reset_mid_mem();
        test_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
